// File: rtl/alu.sv
// 16-bit execute-stage ALU (ADD/SUB/AND/MVN) with live {Z,V,N} flags and a loadable flag register.
// Overflow detection is built only when ALU_OVF_EN is defined; otherwise V reads as 0.
module alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] Ain,
   input  logic [15:0] Bin,
   input  logic [1:0]  ALUop,
   input  logic        loads,
   output logic [15:0] out,
   output logic [2:0]  status,
   output logic [2:0]  status_q
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;

   logic        is_sub;
   logic [15:0] b_opnd;
   logic [15:0] sum;
   logic [15:0] result;
   logic        ovf;
   logic [2:0]  flags_d;
   logic [2:0]  flags_q;

   // SUB shares the adder: Ain + ~Bin + 1; the carry-out is discarded.
   assign is_sub = (ALUop == OP_SUB);
   assign b_opnd = is_sub ? ~Bin : Bin;
   assign sum    = Ain + b_opnd + {15'd0, is_sub};

   always_comb begin
      result = sum;
      case (ALUop)
         OP_ADD:  result = sum;
         OP_SUB:  result = sum;
         OP_AND:  result = Ain & Bin;
         OP_MVN:  result = ~Bin;
         default: result = sum;
      endcase
   end

`ifdef ALU_OVF_EN
   always_comb begin
      ovf = 1'b0;
      if (ALUop == OP_ADD)
         ovf = (Ain[15] == Bin[15]) && (result[15] != Ain[15]);
      else if (ALUop == OP_SUB)
         ovf = (Ain[15] != Bin[15]) && (result[15] != Ain[15]);
   end
`else
   assign ovf = 1'b0;
`endif

   assign out     = result;
   assign status  = {(result == 16'd0), ovf, result[15]};
   assign flags_d = loads ? status : flags_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flags_q <= 3'b000;
      else
         flags_q <= flags_d;
   end

   assign status_q = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: every opcode, flag corner cases and the flag register.
// Expected V bits are masked off when ALU_OVF_EN is undefined.
module tb_alu;

   logic        clk;
   logic        reset;
   logic [15:0] Ain;
   logic [15:0] Bin;
   logic [1:0]  ALUop;
   logic        loads;
   logic [15:0] out;
   logic [2:0]  status;
   logic [2:0]  status_q;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef ALU_OVF_EN
   localparam logic [2:0] VMASK = 3'b111;
`else
   localparam logic [2:0] VMASK = 3'b101;
`endif

   alu dut (
      .clk      (clk),
      .reset    (reset),
      .Ain      (Ain),
      .Bin      (Bin),
      .ALUop    (ALUop),
      .loads    (loads),
      .out      (out),
      .status   (status),
      .status_q (status_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Apply one combinational vector and check out and the live flags.
   task automatic vec(input string tag, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_out, input logic [2:0] exp_st);
      ALUop = op;
      Ain   = a;
      Bin   = b;
      #1;
      chk16({tag, "_out"}, out, exp_out);
      chk3({tag, "_status"}, status, exp_st & VMASK);
   endtask

   initial begin
      reset = 1'b1;
      loads = 1'b0;
      Ain   = 16'd0;
      Bin   = 16'd0;
      ALUop = 2'b00;
      #1;
      chk3("reset_status_q", status_q, 3'b000);

      // loads ignored while reset is high
      loads = 1'b1;
      Ain   = 16'h7FFF;
      Bin   = 16'h0001;
      @(posedge clk); #1;
      chk3("reset_ignores_loads", status_q, 3'b000);
      loads = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      vec("add_0_0",     2'b00, 16'h0000, 16'h0000, 16'h0000, 3'b100);
      vec("add_1_3",     2'b00, 16'h0001, 16'h0003, 16'h0004, 3'b000);
      vec("add_ovf",     2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b011);
      vec("add_neg_ovf", 2'b00, 16'h8000, 16'h8000, 16'h0000, 3'b110);
      vec("add_wrap",    2'b00, 16'hFFFF, 16'h0001, 16'h0000, 3'b100);
      vec("sub_100_24",  2'b01, 16'd100,  16'd24,   16'd76,   3'b000);
      vec("sub_0_0",     2'b01, 16'h0000, 16'h0000, 16'h0000, 3'b100);
      vec("sub_0_1",     2'b01, 16'h0000, 16'h0001, 16'hFFFF, 3'b001);
      vec("sub_ovf",     2'b01, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
      vec("sub_ovf_pos", 2'b01, 16'h7FFF, 16'hFFFF, 16'h8000, 3'b011);
      vec("and_0_0",     2'b10, 16'h0000, 16'h0000, 16'h0000, 3'b100);
      vec("and_mix",     2'b10, 16'h6F02, 16'hA6CB, 16'h2602, 3'b000);
      vec("and_neg",     2'b10, 16'hFFFF, 16'h8001, 16'h8001, 3'b001);
      vec("mvn_0",       2'b11, 16'h1234, 16'h0000, 16'hFFFF, 3'b001);
      vec("mvn_mix",     2'b11, 16'h8C08, 16'h8E38, 16'h71C7, 3'b000);
      vec("mvn_zero",    2'b11, 16'h7FFF, 16'hFFFF, 16'h0000, 3'b100);

      // Flag register: load, hold, asynchronous clear
      @(negedge clk);
      ALUop = 2'b00; Ain = 16'h7FFF; Bin = 16'h0001; loads = 1'b1;
      @(posedge clk); #1;
      chk3("flags_load", status_q, 3'b011 & VMASK);
      loads = 1'b0;
      ALUop = 2'b01; Ain = 16'h0000; Bin = 16'h0000;
      @(posedge clk); #1;
      chk3("flags_hold", status_q, 3'b011 & VMASK);
      chk3("flags_hold_live", status, 3'b100);
      #2;
      reset = 1'b1;
      #1;
      chk3("flags_async_clear", status_q, 3'b000);
      chk16("reset_out_unaffected", out, 16'h0000);
      chk3("reset_status_unaffected", status, 3'b100);
      @(negedge clk);
      reset = 1'b0;
      loads = 1'b1;
      @(posedge clk); #1;
      chk3("flags_load_after_reset", status_q, 3'b100);
      loads = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL timeout: observed no finish expected finish before 5000");
      $fatal(1, "timeout");
   end

endmodule
